// File: rtl/button_debounce_if.sv
// Button debouncer signal bundle: raw active-low pin in, clean level and strobes out.
interface button_debounce_if;
    logic btn_n_in;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic hold_pulse;

    modport master (
        output btn_n_in,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  hold_pulse
    );

    modport slave (
        input  btn_n_in,
        output pressed,
        output press_pulse,
        output release_pulse,
        output hold_pulse
    );
endinterface

// File: rtl/button_debounce.sv
// Synchronising counter-based debouncer for one active-low keypad column on hwclk.
// Define BUTTON_DEBOUNCE_HOLD_EN to build the long-press (hold_pulse) detector.
module button_debounce #(
    parameter int unsigned STABLE_CYCLES = 120000,
    parameter int unsigned CNT_WIDTH     = 17,
    parameter int unsigned HOLD_CYCLES   = 12000000,
    parameter int unsigned HOLD_WIDTH    = 24
) (
    input logic              hwclk,
    input logic              rst_n,
    button_debounce_if.slave bus
);

    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    if ((STABLE_CYCLES < 2) || (CNT_WIDTH < 1) || (HOLD_CYCLES < 1) || (HOLD_WIDTH < 1) ||
        (64'(STABLE_CYCLES) > (64'd1 << CNT_WIDTH)) ||
        (64'(HOLD_CYCLES) > (64'd1 << HOLD_WIDTH))) begin : g_bad_cfg
        $error("button_debounce: illegal parameter combination");
    end

    logic                 sync_meta;
    logic                 sync;
    logic [1:0]           state;
    logic [1:0]           state_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 pressed_q;
    logic                 pressed_d;
    logic                 press_pulse_q;
    logic                 press_pulse_d;
    logic                 release_pulse_q;
    logic                 release_pulse_d;

    // Two-flop synchroniser, FSM state and registered outputs.
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            sync_meta       <= 1'b1;
            sync            <= 1'b1;
            state           <= RELEASED;
            cnt             <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            sync_meta       <= bus.btn_n_in;
            sync            <= sync_meta;
            state           <= state_d;
            cnt             <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    // Any opposite sample during a wait state drops back and restarts from zero.
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        pressed_d       = pressed_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_WIDTH'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d       = PRESSED;
                    cnt_d         = '0;
                    pressed_d     = 1'b1;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_WIDTH'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_d         = RELEASED;
                    cnt_d           = '0;
                    pressed_d       = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.pressed       = pressed_q;
    assign bus.press_pulse   = press_pulse_q;
    assign bus.release_pulse = release_pulse_q;

`ifdef BUTTON_DEBOUNCE_HOLD_EN
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic [HOLD_WIDTH-1:0] hold_cnt_d;
    logic                  hold_done;
    logic                  hold_done_d;
    logic                  hold_pulse_q;
    logic                  hold_pulse_d;

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            hold_cnt     <= '0;
            hold_done    <= 1'b0;
            hold_pulse_q <= 1'b0;
        end else begin
            hold_cnt     <= hold_cnt_d;
            hold_done    <= hold_done_d;
            hold_pulse_q <= hold_pulse_d;
        end
    end

    // Timer restarts only on an accepted press, so release bounces never re-arm it.
    always_comb begin
        hold_cnt_d   = hold_cnt;
        hold_done_d  = hold_done;
        hold_pulse_d = 1'b0;
        if ((state == PRESSED) || (state == RELEASE_WAIT)) begin
            if (hold_cnt == HOLD_LAST) begin
                if (!hold_done) begin
                    hold_pulse_d = 1'b1;
                    hold_done_d  = 1'b1;
                end
            end else begin
                hold_cnt_d = hold_cnt + HOLD_WIDTH'(1);
            end
        end
        if (((state == PRESS_WAIT) && (state_d == PRESSED)) ||
            ((state == RELEASE_WAIT) && (state_d == RELEASED))) begin
            hold_cnt_d  = '0;
            hold_done_d = 1'b0;
        end
    end

    assign bus.hold_pulse = hold_pulse_q;
`else
    assign bus.hold_pulse = 1'b0;
`endif

endmodule
